sle_word_capture: RTL and testbench
===================================

# sle_word_capture

Serial-to-parallel capture stage that sits directly downstream of an SLE register bit. It consumes the SLE's registered Q output one qualified bit per clock and assembles the bits into WIDTH-bit words. Completed words are presented on a valid/ready output holding register. It turns the single-bit SLE stream into words for the next pipeline stage and flags any word lost to backpressure.

## Interface
- WIDTH, 8: bits per word; legal range 1..32.
- MSB_FIRST, 1: 1 = first captured bit lands in Word_out[WIDTH-1]; 0 = first bit lands in Word_out[0].

- Clk  input  1  single clock; all state updates on its rising edge.
- Rst  input  1  synchronous, active-high reset.
- Q_in  input  1  serial data bit, driven by the upstream SLE Q.
- Bit_vld  input  1  Q_in is a valid bit this cycle; mirrors the upstream SLE En, delayed one cycle.
- Frame_start  input  1  discards any partial word; an accompanying valid bit becomes bit 0 of a new word.
- Word_rdy  input  1  downstream accepts Word_out this cycle.
- Word_out  output  WIDTH  assembled word, stable while Word_vld=1.
- Word_vld  output  1  Word_out holds an unconsumed word.
- Busy  output  1  a partial word is in progress (bit count ≠ 0).
- Overflow  output  1  sticky: a completed word was dropped.

## Operation
- The collector FSM has two states:
  - IDLE: bit count = 0. A valid bit moves the FSM to COLLECT, or to IDLE again with a word completed when WIDTH=1.
  - COLLECT: 0 < count < WIDTH. A valid bit increments the count. When the WIDTH-th bit arrives, the word completes and the FSM returns to IDLE.
- Bit placement:
  - MSB_FIRST=1: the shift register shifts left and Q_in enters at bit 0, so the first bit ends at the MSB.
  - MSB_FIRST=0: the shift register shifts right and Q_in enters at bit WIDTH-1, so the first bit ends at the LSB.
- Bit_vld=0 cycles are gaps. Count and shift contents hold.
- Frame_start=1:
  - Count is forced to 0 and partial bits are discarded. No flag is raised.
  - If Bit_vld=1 in the same cycle, Q_in is taken as the first bit (count becomes 1).
  - Frame_start has no effect on the output register.
- Output register:
  - When a word completes and the register is empty, or is being consumed this cycle (Word_vld & Word_rdy), the word loads and Word_vld=1 on the next cycle.
  - When a word completes while Word_vld=1 and Word_rdy=0, the new word is dropped, Word_out is unchanged, and Overflow is set.
  - A consume with no completion in the same cycle clears Word_vld on the next cycle.
- Overflow clears only on Rst.
- Width rules:
  - Count register is $clog2(WIDTH+1) bits.
  - Count never exceeds WIDTH-1 at a clock edge.

## Timing
- Reset values: Word_out=0, Word_vld=0, Busy=0, Overflow=0 (and Word_par=0 when the parity macro is defined). FSM=IDLE, count=0, shift register=0.
- Rst has priority over every other input. If asserted mid-word, the partial bits and any pending output word are lost.
- Latency: the edge that samples the last bit of a word is followed by Word_vld=1 and valid Word_out in the same cycle. That is one cycle after the bit is present on Q_in.
- Sustained throughput: one word per WIDTH cycles with Bit_vld held at 1 and Word_rdy held at 1, with no bubble.
- Word_out and Word_vld are registered. There is no combinational path from any input to any output.
- Busy is registered and equals (count ≠ 0).

## Configuration
- Macro: CAPTURE_PARITY_EN.
  - Defined: adds the output Word_par (1 bit), which is the even parity (XOR reduction) of the loaded word. Word_par is registered in the same edge as Word_out, holds with it, and is also left unchanged on a dropped word.
  - Undefined: the Word_par port and its logic are absent. All other behaviour is identical.

## Test plan
- Serial word: WIDTH=8, MSB_FIRST=1, Rst then Bit_vld=1 for 8 cycles with Q_in=1,0,1,1,0,0,1,0 and Word_rdy=1 -> Word_out=8'hB2 with Word_vld=1 the cycle after the 8th edge, Word_vld=0 the next cycle, Busy=1 during cycles 2-8, Word_par=0 when CAPTURE_PARITY_EN is defined.
- Bit order: MSB_FIRST=0 with the same stream -> Word_out=8'h4D.
- Backpressure: hold Word_rdy=0 after 8'hB2, then shift in 8'h5A -> Overflow=1, Word_out stays 8'hB2. Then Word_rdy=1 for one cycle -> Word_vld=0, Overflow still 1.
- Consume and complete: the 8th bit of 8'h3C arrives in the same cycle that 8'hB2 is consumed -> Word_vld stays 1, Word_out=8'h3C, Overflow unchanged.
- Gaps and reframe:
  - Shift 3 bits, assert Frame_start with Bit_vld=1 and Q_in=1, then 7 more 1-bits with random Bit_vld gaps -> exactly one word, 8'hFF.
  - Frame_start alone mid-word -> Busy=0.
- Reset mid-operation: assert Rst after 5 bits with Word_vld=1 and Overflow=1 -> next cycle all outputs are 0. A following 8-bit stream yields a correct word.

Source files
------------

// File: rtl/sle_word_capture.sv
// Serial-to-parallel capture of a qualified SLE bit stream into WIDTH-bit words.
// Define CAPTURE_PARITY_EN to add the registered even-parity output Word_par.
module sle_word_capture #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Q_in,
  input  logic             Bit_vld,
  input  logic             Frame_start,
  input  logic             Word_rdy,
  output logic [WIDTH-1:0] Word_out,
  output logic             Word_vld,
  output logic             Busy,
`ifdef CAPTURE_PARITY_EN
  output logic             Word_par,
`endif
  output logic             Overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_base;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_base;
  logic [WIDTH-1:0] shift_nxt;
  logic             word_done;
  logic             load;
  logic             drop;

  // Frame_start discards the partial word before the current bit is applied,
  // so a bit arriving with it becomes the first bit of the new word.
  always_comb begin
    count_base = Frame_start ? '0 : count;
    shift_base = Frame_start ? '0 : shift;
    count_nxt  = count_base;
    shift_nxt  = shift_base;
    word_done  = 1'b0;
    state_nxt  = state;

    if (Bit_vld) begin
      if (MSB_FIRST)
        shift_nxt = (shift_base << 1) | WIDTH'(Q_in);
      else
        shift_nxt = (shift_base >> 1) | (WIDTH'(Q_in) << (WIDTH - 1));

      if (count_base == CW'(WIDTH - 1)) begin
        word_done = 1'b1;
        count_nxt = '0;
      end else begin
        count_nxt = count_base + CW'(1);
      end
    end

    unique case (state)
      IDLE:    state_nxt = (Bit_vld && !word_done) ? COLLECT : IDLE;
      COLLECT: state_nxt = (word_done || (Frame_start && !Bit_vld)) ? IDLE : COLLECT;
    endcase
  end

  // A finished word may take the holding register only if it is empty or draining now.
  assign load = word_done && (!Word_vld || Word_rdy);
  assign drop = word_done && Word_vld && !Word_rdy;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      count    <= '0;
      shift    <= '0;
      Busy     <= 1'b0;
      Word_out <= '0;
      Word_vld <= 1'b0;
      Overflow <= 1'b0;
`ifdef CAPTURE_PARITY_EN
      Word_par <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      shift <= shift_nxt;
      Busy  <= (state_nxt == COLLECT);

      if (load) begin
        Word_out <= shift_nxt;
        Word_vld <= 1'b1;
`ifdef CAPTURE_PARITY_EN
        Word_par <= ^shift_nxt;
`endif
      end else if (Word_vld && Word_rdy) begin
        Word_vld <= 1'b0;
      end

      if (drop)
        Overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sle_word_capture.sv
// Self-checking bench for sle_word_capture: both bit orders driven from one stream
// and compared every cycle against a bit-queue reference model.
module tb_sle_word_capture;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         q_in;
  logic         bit_vld;
  logic         frame_start;
  logic         word_rdy;

  logic [W-1:0] word_out_msb;
  logic         word_vld_msb;
  logic         busy_msb;
  logic         ovf_msb;
  logic [W-1:0] word_out_lsb;
  logic         word_vld_lsb;
  logic         busy_lsb;
  logic         ovf_lsb;
`ifdef CAPTURE_PARITY_EN
  logic         par_msb;
  logic         par_lsb;
`endif

  int checks = 0;
  int passes = 0;

  sle_word_capture #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .Clk         (clk),
    .Rst         (rst),
    .Q_in        (q_in),
    .Bit_vld     (bit_vld),
    .Frame_start (frame_start),
    .Word_rdy    (word_rdy),
    .Word_out    (word_out_msb),
    .Word_vld    (word_vld_msb),
    .Busy        (busy_msb),
`ifdef CAPTURE_PARITY_EN
    .Word_par    (par_msb),
`endif
    .Overflow    (ovf_msb)
  );

  sle_word_capture #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .Clk         (clk),
    .Rst         (rst),
    .Q_in        (q_in),
    .Bit_vld     (bit_vld),
    .Frame_start (frame_start),
    .Word_rdy    (word_rdy),
    .Word_out    (word_out_lsb),
    .Word_vld    (word_vld_lsb),
    .Busy        (busy_lsb),
`ifdef CAPTURE_PARITY_EN
    .Word_par    (par_lsb),
`endif
    .Overflow    (ovf_lsb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    else
      passes++;
  endtask

  // One clock per call: inputs applied now, outputs settled on return.
  task automatic applyStimulus(input logic r, input logic v, input logic q,
                               input logic fs, input logic rdy);
    rst         = r;
    bit_vld     = v;
    q_in        = q;
    frame_start = fs;
    word_rdy    = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic sendBits(input logic [7:0] w, input logic rdy_body, input logic rdy_last);
    for (int i = 7; i >= 0; i--)
      applyStimulus(1'b0, 1'b1, w[i], 1'b0, (i == 0) ? rdy_last : rdy_body);
  endtask

  // Reference model: bits collected in arrival order, word formed once W arrive.
  bit           bits[$];
  logic [W-1:0] m_out_msb = '0;
  logic [W-1:0] m_out_lsb = '0;
  logic         m_vld     = 1'b0;
  logic         m_ovf     = 1'b0;
  logic         m_busy    = 1'b0;
  bit           model_live = 1'b0;

  always @(posedge clk) begin : model_blk
    bit           done;
    logic [W-1:0] w_msb;
    logic [W-1:0] w_lsb;
    w_msb = '0;
    w_lsb = '0;
    if (rst) begin
      bits.delete();
      m_vld      = 1'b0;
      m_out_msb  = '0;
      m_out_lsb  = '0;
      m_ovf      = 1'b0;
      model_live = 1'b1;
    end else begin
      done = 1'b0;
      if (frame_start) bits.delete();
      if (bit_vld) begin
        bits.push_back(q_in);
        if (bits.size() == W) begin
          for (int i = 0; i < W; i++) begin
            w_msb[W-1-i] = bits[i];
            w_lsb[i]     = bits[i];
          end
          done = 1'b1;
          bits.delete();
        end
      end
      if (done) begin
        if (!m_vld || word_rdy) begin
          m_out_msb = w_msb;
          m_out_lsb = w_lsb;
          m_vld     = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_vld && word_rdy) begin
        m_vld = 1'b0;
      end
    end
    m_busy = (bits.size() != 0);
  end

  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("vld_msb",  {31'd0, word_vld_msb}, {31'd0, m_vld});
      checkOutput("vld_lsb",  {31'd0, word_vld_lsb}, {31'd0, m_vld});
      checkOutput("out_msb",  {24'd0, word_out_msb}, {24'd0, m_out_msb});
      checkOutput("out_lsb",  {24'd0, word_out_lsb}, {24'd0, m_out_lsb});
      checkOutput("busy_msb", {31'd0, busy_msb},     {31'd0, m_busy});
      checkOutput("busy_lsb", {31'd0, busy_lsb},     {31'd0, m_busy});
      checkOutput("ovf_msb",  {31'd0, ovf_msb},      {31'd0, m_ovf});
      checkOutput("ovf_lsb",  {31'd0, ovf_lsb},      {31'd0, m_ovf});
`ifdef CAPTURE_PARITY_EN
      checkOutput("par_msb",  {31'd0, par_msb},      {31'd0, ^m_out_msb});
      checkOutput("par_lsb",  {31'd0, par_lsb},      {31'd0, ^m_out_lsb});
`endif
    end
  end

  initial begin
    int gaps;
    rst = 1'b1; bit_vld = 1'b0; q_in = 1'b0; frame_start = 1'b0; word_rdy = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_vld",  {31'd0, word_vld_msb}, 32'd0);
    checkOutput("reset_out",  {24'd0, word_out_msb}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy_msb},     32'd0);
    checkOutput("reset_ovf",  {31'd0, ovf_msb},      32'd0);

    // Serial word 1,0,1,1,0,0,1,0
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("busy_after_bit1", {31'd0, busy_msb}, 32'd1);
    for (int i = 6; i >= 1; i--) applyStimulus(1'b0, 1'b1, (8'hB2 >> i) & 1'b1, 1'b0, 1'b1);
    checkOutput("busy_after_bit7", {31'd0, busy_msb},     32'd1);
    checkOutput("vld_before_last", {31'd0, word_vld_msb}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("b2_vld",     {31'd0, word_vld_msb}, 32'd1);
    checkOutput("b2_out",     {24'd0, word_out_msb}, 32'hB2);
    checkOutput("b2_lsb_out", {24'd0, word_out_lsb}, 32'h4D);
    checkOutput("b2_busy",    {31'd0, busy_msb},     32'd0);
`ifdef CAPTURE_PARITY_EN
    checkOutput("b2_par",     {31'd0, par_msb},      32'd0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("b2_consumed", {31'd0, word_vld_msb}, 32'd0);

    // Backpressure drops 5A
    sendBits(8'hB2, 1'b0, 1'b0);
    sendBits(8'h5A, 1'b0, 1'b0);
    checkOutput("bp_ovf", {31'd0, ovf_msb},      32'd1);
    checkOutput("bp_out", {24'd0, word_out_msb}, 32'hB2);
    checkOutput("bp_vld", {31'd0, word_vld_msb}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_drain_vld", {31'd0, word_vld_msb}, 32'd0);
    checkOutput("bp_drain_ovf", {31'd0, ovf_msb},      32'd1);

    // Consume and complete in the same cycle
    sendBits(8'hB2, 1'b0, 1'b0);
    sendBits(8'h3C, 1'b0, 1'b1);
    checkOutput("cc_vld", {31'd0, word_vld_msb}, 32'd1);
    checkOutput("cc_out", {24'd0, word_out_msb}, 32'h3C);
    checkOutput("cc_ovf", {31'd0, ovf_msb},      32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reframe with gaps
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) applyStimulus(1'b0, 1'b0, 1'($urandom), 1'b0, 1'b1);
      if (i == 6) checkOutput("rf_no_early_word", {31'd0, word_vld_msb}, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    end
    checkOutput("rf_vld", {31'd0, word_vld_msb}, 32'd1);
    checkOutput("rf_out", {24'd0, word_out_msb}, 32'hFF);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Frame_start alone mid-word
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("fs_busy_before", {31'd0, busy_msb}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("fs_busy_after", {31'd0, busy_msb}, 32'd0);

    // Reset mid-operation
    sendBits(8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_rst_vld", {31'd0, word_vld_msb}, 32'd1);
    checkOutput("pre_rst_ovf", {31'd0, ovf_msb},      32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_vld",  {31'd0, word_vld_msb}, 32'd0);
    checkOutput("rst_out",  {24'd0, word_out_msb}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_msb},     32'd0);
    checkOutput("rst_ovf",  {31'd0, ovf_msb},      32'd0);
    sendBits(8'hC3, 1'b1, 1'b1);
    checkOutput("post_rst_out", {24'd0, word_out_msb}, 32'hC3);
    checkOutput("post_rst_vld", {31'd0, word_vld_msb}, 32'd1);

    // Sustained back-to-back words
    for (int i = 0; i < 4 * W; i++) applyStimulus(1'b0, 1'b1, 1'($urandom), 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      applyStimulus(($urandom % 300) == 0, ($urandom % 4) != 0, 1'($urandom),
                    ($urandom % 40) == 0, ($urandom % 3) != 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
